// File: rtl/attention_pkg.sv
// Shared types and helpers for the attention datapath.
// Holds the per-token precision codes, the A*V engine state encoding and
// the accumulator width derivation used by attention_av_mac_engine.
package attention_pkg;

  // Per-key-token precision code applied to V before the multiply.
  // Codes 4..15 are reserved and treated as full width.
  typedef enum logic [3:0] {
    PREC_INT4  = 4'd0,
    PREC_INT8  = 4'd1,
    PREC_FP16  = 4'd2,
    PREC_PRUNE = 4'd3
  } prec_code_e;

  // Control states of the A*V engine.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } av_state_e;

  // The sum of seq_len full-width products needs 2*data_width bits plus
  // clog2(seq_len) carry bits, so the accumulator can never wrap.
  function automatic int av_acc_width(input int data_width, input int seq_len);
    return 2 * data_width + $clog2(seq_len);
  endfunction

endpackage

// File: rtl/av_mac_lane.sv
// One multiply-accumulate lane of the attention A*V engine.
// Downcasts V according to the token precision code, multiplies by A and
// accumulates into a wide register that can be cleared synchronously.
module av_mac_lane
  import attention_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 35
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] v_i,
  input  logic [3:0]            prec_i,
  output logic [ACC_W-1:0]      acc_o
);

  localparam logic [DATA_WIDTH-1:0] MASK4 = DATA_WIDTH'(4'hF);
  localparam logic [DATA_WIDTH-1:0] MASK8 = DATA_WIDTH'(8'hFF);

  logic [DATA_WIDTH-1:0]   v_dn;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;

  // Downcast V, form the full-width product and the next accumulator value.
  always_comb begin
    v_dn = v_i;
    case (prec_i)
      PREC_INT4:  v_dn = v_i & MASK4;
      PREC_INT8:  v_dn = v_i & MASK8;
      PREC_PRUNE: v_dn = '0;
      default:    v_dn = v_i;
    endcase
    prod  = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, v_dn};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register; clear has priority over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/attention_av_mac_engine.sv
// Sequential attention A*V engine: Z[l,n,e] = sum_l2 A[l,n,l2]*down(V[l2,n,e]).
// LANES lanes cover one chunk of e per pass; one key token l2 per MAC cycle,
// followed by one WRITE cycle that stores the chunk into Z_out.
// Optional feature macro: AV_SATURATE_EN (saturate instead of wrap on store).
// E must be divisible by LANES.
module attention_av_mac_engine
  import attention_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8,
  parameter int LANES      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]  V_in,
  input  logic [3:0]                   token_precision [0:L-1],
  output logic [DATA_WIDTH*L*N*E-1:0]  Z_out,
  output logic                         out_valid
);

  localparam int CH    = E / LANES;
  localparam int ACC_W = av_acc_width(DATA_WIDTH, L);
  localparam int LW    = (L  > 1) ? $clog2(L)  : 1;
  localparam int NW    = (N  > 1) ? $clog2(N)  : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [LW-1:0] L_LAST = LW'(L - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

  av_state_e     state_q;
  logic [LW-1:0] l_q;
  logic [LW-1:0] l2_q;
  logic [NW-1:0] n_q;
  logic [CW-1:0] c_q;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;

  logic [DATA_WIDTH*L*N*L-1:0] a_q;
  logic [DATA_WIDTH*L*N*E-1:0] v_q;
  logic [3:0]                  tp_q [0:L-1];

  logic [DATA_WIDTH-1:0] a_arr [L][N][L];
  logic [DATA_WIDTH-1:0] v_arr [L][N][CH][LANES];
  logic [DATA_WIDTH-1:0] a_cur;

  logic accept;
  logic acc_clr;
  logic acc_en;

  assign accept  = (state_q == ST_IDLE) && start;
  assign acc_clr = accept || (state_q == ST_WRITE);
  assign acc_en  = (state_q == ST_MAC);

  // Convert a finished accumulator into the stored output element.
  function automatic logic [DATA_WIDTH-1:0] z_store(input logic [ACC_W-1:0] acc);
`ifdef AV_SATURATE_EN
    if (|acc[ACC_W-1:DATA_WIDTH]) begin
      return '1;
    end
    return acc[DATA_WIDTH-1:0];
`else
    return acc[DATA_WIDTH-1:0];
`endif
  endfunction

  // Operand snapshot taken at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= A_in;
      v_q  <= V_in;
      tp_q <= token_precision;
    end
  end

  // Index views of the flattened snapshots so counters select directly.
  for (genvar al = 0; al < L; al++) begin : g_a_l
    for (genvar an = 0; an < N; an++) begin : g_a_n
      for (genvar ak = 0; ak < L; ak++) begin : g_a_k
        assign a_arr[al][an][ak] = a_q[((al*N+an)*L+ak)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar vk = 0; vk < L; vk++) begin : g_v_k
    for (genvar vn = 0; vn < N; vn++) begin : g_v_n
      for (genvar vc = 0; vc < CH; vc++) begin : g_v_c
        for (genvar vg = 0; vg < LANES; vg++) begin : g_v_g
          assign v_arr[vk][vn][vc][vg] =
            v_q[((vk*N+vn)*E+vc*LANES+vg)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign a_cur = a_arr[l_q][n_q][l2_q];

  // Control FSM: token loop inside MAC, then chunk/n/l advance in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      l2_q    <= '0;
      n_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_MAC;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            l_q     <= '0;
            l2_q    <= '0;
            n_q     <= '0;
            c_q     <= '0;
          end
        end
        ST_MAC: begin
          if (l2_q == L_LAST) begin
            state_q <= ST_WRITE;
          end else begin
            l2_q <= l2_q + LW'(1);
          end
        end
        ST_WRITE: begin
          l2_q    <= '0;
          state_q <= ST_MAC;
          if (c_q != C_LAST) begin
            c_q <= c_q + CW'(1);
          end else begin
            c_q <= '0;
            if (n_q != N_LAST) begin
              n_q <= n_q + NW'(1);
            end else begin
              n_q <= '0;
              if (l_q != L_LAST) begin
                l_q <= l_q + LW'(1);
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                valid_q <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-lane datapath: MAC lane plus its slice of the output buffer.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ACC_W-1:0]      acc;
    logic [DATA_WIDTH-1:0] z_q [L][N][CH];

    av_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_W     (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .a_i   (a_cur),
      .v_i   (v_arr[l2_q][n_q][c_q][g]),
      .prec_i(tp_q[l2_q]),
      .acc_o (acc)
    );

    // Store the finished chunk element; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q <= '{default: '0};
      end else if (state_q == ST_WRITE) begin
        z_q[l_q][n_q][c_q] <= z_store(acc);
      end
    end

    for (genvar zl = 0; zl < L; zl++) begin : g_z_l
      for (genvar zn = 0; zn < N; zn++) begin : g_z_n
        for (genvar zc = 0; zc < CH; zc++) begin : g_z_c
          assign Z_out[((zl*N+zn)*E+zc*LANES+g)*DATA_WIDTH +: DATA_WIDTH] = z_q[zl][zn][zc];
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_attention_av_mac_engine.sv
// Self-checking bench for attention_av_mac_engine (L=4, N=1, E=4, LANES=2).
module tb_attention_av_mac_engine;

  localparam int DW  = 16;
  localparam int TL  = 4;
  localparam int TN  = 1;
  localparam int TE  = 4;
  localparam int TLN = 2;
  localparam int AW  = DW * TL * TN * TL;
  localparam int VW  = DW * TL * TN * TE;
  localparam int OPC = TN * TL * (TE / TLN) * (TL + 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] A_in;
  logic [VW-1:0] V_in;
  logic [3:0]    tp [0:TL-1];
  logic [VW-1:0] Z_out;
  logic          out_valid;

  int vectors;
  int miscompares;

  attention_av_mac_engine #(
    .DATA_WIDTH(DW), .L(TL), .N(TN), .E(TE), .LANES(TLN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .A_in           (A_in),
    .V_in           (V_in),
    .token_precision(tp),
    .Z_out          (Z_out),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: direct sum over key tokens with the precision rules.
  function automatic logic [VW-1:0] model_z(input logic [AW-1:0] a, input logic [VW-1:0] v,
                                           input logic [3:0] p [0:TL-1]);
    logic [VW-1:0] z;
    longint unsigned s, av, vv;
    z = '0;
    for (int l = 0; l < TL; l++)
      for (int n = 0; n < TN; n++)
        for (int e = 0; e < TE; e++) begin
          s = 0;
          for (int k = 0; k < TL; k++) begin
            av = longint'(a[((l*TN+n)*TL+k)*DW +: DW]);
            vv = longint'(v[((k*TN+n)*TE+e)*DW +: DW]);
            if (p[k] == 4'd0) vv = vv % 16;
            else if (p[k] == 4'd1) vv = vv % 256;
            else if (p[k] == 4'd3) vv = 0;
            s = s + av * vv;
          end
`ifdef AV_SATURATE_EN
          if (s > 65535) s = 65535;
`else
          s = s % 65536;
`endif
          z[((l*TN+n)*TE+e)*DW +: DW] = DW'(s);
        end
    return z;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < TL*TN*TL; i++) A_in[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < TL*TN*TE; i++) V_in[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < TL; i++) tp[i] = 4'($urandom_range(0, 15));
  endtask

  // Start one operation and follow it until done (bounded).
  task automatic run_op(input bit disturb, output int done_cyc, output int busy_cnt,
                        output int busy_last);
    done_cyc = -1; busy_cnt = 0; busy_last = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) begin busy_cnt++; busy_last = c; end
      if (done) begin done_cyc = c; break; end
      start = disturb && (c == 5 || c == 20);
      if (disturb && c == 3) A_in = ~A_in;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (Z_out !== '0) begin miscompares++; $display("FAIL reset_z got %h want 0", Z_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_timing();
    int dc, bc, bl;
    logic [VW-1:0] exp_z;
    for (int i = 0; i < TL*TN*TL; i++) A_in[i*DW +: DW] = 16'd1;
    for (int i = 0; i < TL*TN*TE; i++) V_in[i*DW +: DW] = 16'd2;
    for (int i = 0; i < TL; i++) tp[i] = 4'd2;
    for (int i = 0; i < TL*TN*TE; i++) exp_z[i*DW +: DW] = 16'd8;
    run_op(1'b0, dc, bc, bl);
    vectors += 6;
    if (dc != OPC) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", dc, OPC); end
    if (bc != OPC - 1 || bl != OPC - 1) begin
      miscompares++; $display("FAIL basic_busy got cnt=%0d last=%0d want %0d", bc, bl, OPC - 1);
    end
    if (Z_out !== exp_z) begin miscompares++; $display("FAIL basic_z got %h want %h", Z_out, exp_z); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", out_valid); end
    @(negedge clk);
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_hold got %b want 1", out_valid); end
  endtask

  task automatic test_precision();
    int dc, bc, bl;
    logic [3:0]  codes [3];
    logic [15:0] want [3];
    logic [VW-1:0] exp_z;
    codes = '{4'd0, 4'd1, 4'd3};
    want  = '{16'h0003, 16'h0023, 16'h0000};
    for (int i = 0; i < TL*TN*TE; i++) V_in[i*DW +: DW] = 16'h0123;
    for (int l = 0; l < TL; l++)
      for (int k = 0; k < TL; k++) A_in[(l*TL+k)*DW +: DW] = (k == 0) ? 16'd1 : 16'd0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < TL; i++) tp[i] = 4'd2;
      tp[0] = codes[t];
      for (int i = 0; i < TL*TN*TE; i++) exp_z[i*DW +: DW] = want[t];
      run_op(1'b0, dc, bc, bl);
      vectors += 2;
      if (dc != OPC) begin miscompares++; $display("FAIL prec%0d_done got %0d want %0d", t, dc, OPC); end
      if (Z_out !== exp_z) begin miscompares++; $display("FAIL prec%0d_z got %h want %h", t, Z_out, exp_z); end
    end
  endtask

  task automatic test_overflow();
    int dc, bc, bl;
    logic [VW-1:0] exp_z;
    A_in = '1; V_in = '1;
    for (int i = 0; i < TL; i++) tp[i] = 4'd2;
`ifdef AV_SATURATE_EN
    for (int i = 0; i < TL*TN*TE; i++) exp_z[i*DW +: DW] = 16'hFFFF;
`else
    for (int i = 0; i < TL*TN*TE; i++) exp_z[i*DW +: DW] = 16'h0004;
`endif
    run_op(1'b0, dc, bc, bl);
    vectors++;
    if (Z_out !== exp_z) begin miscompares++; $display("FAIL overflow_z got %h want %h", Z_out, exp_z); end
  endtask

  task automatic test_ignore_start();
    int dc, bc, bl, extra;
    logic [VW-1:0] exp_z;
    randomize_inputs();
    exp_z = model_z(A_in, V_in, tp);
    run_op(1'b1, dc, bc, bl);
    vectors += 3;
    if (dc != OPC) begin miscompares++; $display("FAIL ignore_done got %0d want %0d", dc, OPC); end
    if (Z_out !== exp_z) begin miscompares++; $display("FAIL ignore_z got %h want %h", Z_out, exp_z); end
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    if (extra != 0) begin miscompares++; $display("FAIL ignore_extra_activity got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, bl;
    logic [VW-1:0] exp_z;
    randomize_inputs();
    run_op(1'b0, dc, bc, bl);
    randomize_inputs();
    exp_z = model_z(A_in, V_in, tp);
    start = 1'b1;
    @(negedge clk);
    vectors += 5;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done got busy=%b want 0", busy); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_idle got %b want 1", out_valid); end
    @(negedge clk);
    start = 1'b0;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept got busy=%b valid=%b want 1/0", busy, out_valid);
    end
    dc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    if (dc != OPC) begin miscompares++; $display("FAIL b2b_done got %0d want %0d", dc, OPC); end
    if (Z_out !== exp_z) begin miscompares++; $display("FAIL b2b_z got %h want %h", Z_out, exp_z); end
  endtask

  task automatic test_async_reset();
    int dc, bc, bl;
    logic [VW-1:0] exp_z;
    randomize_inputs();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done got %b want 0", done); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", out_valid); end
    if (Z_out !== '0) begin miscompares++; $display("FAIL arst_z got %h want 0", Z_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    randomize_inputs();
    exp_z = model_z(A_in, V_in, tp);
    run_op(1'b0, dc, bc, bl);
    vectors += 2;
    if (dc != OPC) begin miscompares++; $display("FAIL arst_rerun_done got %0d want %0d", dc, OPC); end
    if (Z_out !== exp_z) begin miscompares++; $display("FAIL arst_rerun_z got %h want %h", Z_out, exp_z); end
  endtask

  task automatic test_random();
    int dc, bc, bl;
    logic [VW-1:0] exp_z;
    for (int it = 0; it < 6; it++) begin
      randomize_inputs();
      exp_z = model_z(A_in, V_in, tp);
      run_op(1'b0, dc, bc, bl);
      vectors += 2;
      if (dc != OPC) begin miscompares++; $display("FAIL rand%0d_done got %0d want %0d", it, dc, OPC); end
      if (Z_out !== exp_z) begin miscompares++; $display("FAIL rand%0d_z got %h want %h", it, Z_out, exp_z); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    start = 1'b0;
    A_in = '0;
    V_in = '0;
    for (int i = 0; i < TL; i++) tp[i] = 4'd0;
    test_reset();
    test_basic_timing();
    test_precision();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
